// File: rtl/reg_bank_wr_arbiter_if.sv
// reg_bank_wr_arbiter_if
//   Bundles the requester side and the bank write side of the Banco A
//   write-port arbiter.
//   Config macro: WR_ARB_LOCK_EN adds the per-requester lock vector.
//   Signals:
//     req[N_REQ]        level write request per requester
//     req_addr[4*N_REQ] flattened register index, requester i at [4i+3:4i]
//     req_data[16*N_REQ] flattened write data, requester i at [16i+15:16i]
//     stall             bank freeze, blocks new grants
//     lock[N_REQ]       (WR_ARB_LOCK_EN only) keep grant on the last winner
//     gnt[N_REQ]        one-hot registered grant pulse
//     wr_en/wr_sel/wr_data  registered bank write strobe, demux select, data
//     err_addr/err_id   illegal-address pulse and offending requester index
//   Modports: master = requesters/bank side, slave = arbiter.
interface reg_bank_wr_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req;
  logic [4*N_REQ-1:0]  req_addr;
  logic [16*N_REQ-1:0] req_data;
  logic                stall;
`ifdef WR_ARB_LOCK_EN
  logic [N_REQ-1:0]    lock;
`endif
  logic [N_REQ-1:0]    gnt;
  logic                wr_en;
  logic [3:0]          wr_sel;
  logic [15:0]         wr_data;
  logic                err_addr;
  logic [2:0]          err_id;

`ifdef WR_ARB_LOCK_EN
  modport master (output req, req_addr, req_data, stall, lock,
                  input  gnt, wr_en, wr_sel, wr_data, err_addr, err_id);
  modport slave  (input  req, req_addr, req_data, stall, lock,
                  output gnt, wr_en, wr_sel, wr_data, err_addr, err_id);
`else
  modport master (output req, req_addr, req_data, stall,
                  input  gnt, wr_en, wr_sel, wr_data, err_addr, err_id);
  modport slave  (input  req, req_addr, req_data, stall,
                  output gnt, wr_en, wr_sel, wr_data, err_addr, err_id);
`endif
endinterface

// File: rtl/reg_bank_wr_arbiter.sv
// reg_bank_wr_arbiter
//   Round-robin write-port arbiter for the 14-entry x 16-bit register bank
//   (Banco A). Grants at most one requester per cycle and drives the bank
//   write demux with registered select/data/strobe. Sole writer of the bank.
//   Config macro: WR_ARB_LOCK_EN -- a locked last winner keeps the port
//   back-to-back until its lock or req drops.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    reg_bank_wr_arbiter_if.slave (requests in, grant/write out)

// Per-requester qualification: eligibility mask and address legality.
module reg_bank_wr_arbiter_lane #(
  parameter int N_REGS = 14
) (
  input  logic       req,
  input  logic       gnt,
  input  logic [3:0] addr,
  output logic       elig,
  output logic       addr_ok
);
  // A requester holding req during its own gnt cycle is not re-granted.
  assign elig    = req & ~gnt;
  assign addr_ok = int'(addr) < N_REGS;
endmodule

module reg_bank_wr_arbiter #(
  parameter int N_REQ  = 4,
  parameter int N_REGS = 14
) (
  input logic                clk,
  input logic                rst_n,
  reg_bank_wr_arbiter_if.slave bus
);
  localparam int PW = $clog2(N_REQ);

  logic [N_REQ-1:0][3:0]  addr_a;
  logic [N_REQ-1:0][15:0] data_a;
  logic [N_REQ-1:0]       elig;
  logic [N_REQ-1:0]       addr_ok;

  logic [N_REQ-1:0] gnt_q;
  logic             wr_en_q;
  logic [3:0]       wr_sel_q;
  logic [15:0]      wr_data_q;
  logic             err_addr_q;
  logic [2:0]       err_id_q;
  logic [PW-1:0]    last_ptr;

  logic             any;
  logic [PW-1:0]    win;
  logic [PW-1:0]    cand;

  assign addr_a = bus.req_addr;
  assign data_a = bus.req_data;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    reg_bank_wr_arbiter_lane #(.N_REGS(N_REGS)) u_lane (
      .req    (bus.req[i]),
      .gnt    (gnt_q[i]),
      .addr   (addr_a[i]),
      .elig   (elig[i]),
      .addr_ok(addr_ok[i])
    );
  end

  // Winner select: first eligible requester after last_ptr, wrapping.
  always_comb begin
    any  = 1'b0;
    win  = last_ptr;
    cand = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = PW'((int'(last_ptr) + 1 + k) % N_REQ);
      if (!any && elig[cand]) begin
        any = 1'b1;
        win = cand;
      end
    end
`ifdef WR_ARB_LOCK_EN
    // Lock overrides round-robin and the gnt mask; last_ptr stays on w.
    if (gnt_q[last_ptr] && bus.req[last_ptr] && bus.lock[last_ptr]) begin
      any = 1'b1;
      win = last_ptr;
    end
`endif
    if (bus.stall) any = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_sel_q   <= '0;
      wr_data_q  <= '0;
      err_addr_q <= 1'b0;
      err_id_q   <= '0;
      last_ptr   <= PW'(N_REQ - 1);
    end else if (any) begin
      gnt_q      <= '0;
      gnt_q[win] <= 1'b1;
      last_ptr   <= win;
      // sel/data follow the winner even on an illegal address; the strobe
      // stays low so the bank ignores them.
      wr_sel_q   <= addr_a[win];
      wr_data_q  <= data_a[win];
      wr_en_q    <= addr_ok[win];
      err_addr_q <= ~addr_ok[win];
      if (!addr_ok[win]) err_id_q <= 3'(win);
    end else begin
      gnt_q      <= '0;
      wr_en_q    <= 1'b0;
      err_addr_q <= 1'b0;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_sel   = wr_sel_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.err_addr = err_addr_q;
  assign bus.err_id   = err_id_q;
endmodule
